// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader -- serial configuration loader for the parametrised fabric.
//
// Accepts a framed byte stream (sync byte, payload, optional checksum) over a
// valid/ready handshake and assembles it in a shadow register. The complete
// image is copied to the select buses in a single clock edge, so the fabric
// never sees a partial or corrupted configuration.
//
// Build option:
//   CFG_CHECKSUM_EN  when defined, a trailing checksum byte follows the
//                    payload; the image commits only if
//                    (sum of payload + checksum) mod 256 == 0.
//                    When undefined, the last payload byte commits directly
//                    and error is tied low.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               one-cycle load request (honoured in IDLE/DONE/ERROR)
//   s_data, s_valid     input byte stream
//   s_ready             byte accepted this cycle when s_valid is high
//   brbselect .. bottomioselect  committed configuration image
//   cfg_valid           outputs hold a committed image
//   busy                load in progress
//   error               last load failed its checksum (sticky until start)

module fpga_cfg_loader #(
  parameter int          ROWS      = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [7:0]                   s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [180*(ROWS+1)-1:0]      brbselect,
  output logic [432*ROWS-1:0]          bsbselect,
  output logic [20*ROWS-1:0]           lbselect,
  output logic [6*(ROWS+1)-1:0]        leftioselect,
  output logic [6*(ROWS+1)-1:0]        rightioselect,
  output logic [6*(ROWS+1)-1:0]        topioselect,
  output logic [6*(ROWS+1)-1:0]        bottomioselect,
  output logic                         cfg_valid,
  output logic                         busy,
  output logic                         error
);

  localparam int BRB_W     = 180*(ROWS+1);
  localparam int BSB_W     = 432*ROWS;
  localparam int LB_W      = 20*ROWS;
  localparam int IO_W      = 6*(ROWS+1);
  localparam int CFG_BITS  = BRB_W + BSB_W + LB_W + 4*IO_W;
  localparam int CFG_BYTES = (CFG_BITS + 7) / 8;
  // Number of meaningful bits in the final payload byte (rest is padding).
  localparam int LAST_W    = CFG_BITS - 8*(CFG_BYTES-1);
  localparam int CNT_W     = $clog2(CFG_BYTES + 1);

  localparam int OFF_BSB   = BRB_W;
  localparam int OFF_LB    = OFF_BSB + BSB_W;
  localparam int OFF_L     = OFF_LB + LB_W;
  localparam int OFF_R     = OFF_L + IO_W;
  localparam int OFF_T     = OFF_R + IO_W;
  localparam int OFF_B     = OFF_T + IO_W;

`ifdef CFG_CHECKSUM_EN
  // The last byte must be stored because commit happens one byte later.
  localparam int STORE_BYTES = CFG_BYTES;
  localparam int STORE_BITS  = CFG_BITS;
  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_LOAD, S_CHECK, S_DONE, S_ERROR
  } state_t;
`else
  // The last byte is taken straight from s_data at commit, never stored.
  localparam int STORE_BYTES = CFG_BYTES - 1;
  localparam int STORE_BITS  = 8*(CFG_BYTES-1);
  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_LOAD, S_DONE, S_ERROR
  } state_t;
`endif

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg;
  logic [STORE_BITS-1:0]   shadow;
  logic [CFG_BITS-1:0]     commit_img;
  logic [CFG_BITS-1:0]     cfg_reg;
  logic                    cfg_valid_reg;
  logic                    start_ok;
  logic                    commit;
  logic                    load_acc;
  logic                    last_byte;

  assign load_acc  = (state_reg == S_LOAD) && s_valid;
  assign last_byte = (cnt_reg == CNT_W'(CFG_BYTES-1));

`ifdef CFG_CHECKSUM_EN
  logic [7:0] sum_reg;
  logic [7:0] sum_chk;
  logic       sum_ok;
  logic       set_error;
  logic       error_reg;

  assign sum_chk = sum_reg + s_data;
  assign sum_ok  = (sum_chk == 8'h00);
`endif

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // ---------------------------------------------------------------------
  // FSM: next state and control strobes
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    s_ready    = 1'b0;
    start_ok   = 1'b0;
    commit     = 1'b0;
`ifdef CFG_CHECKSUM_EN
    set_error  = 1'b0;
`endif
    case (state_reg)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_next = S_SYNC;
          start_ok   = 1'b1;
        end
      end
      S_SYNC: begin
        s_ready = 1'b1;
        if (s_valid && (s_data == SYNC_BYTE)) state_next = S_LOAD;
      end
      S_LOAD: begin
        s_ready = 1'b1;
        if (s_valid && last_byte) begin
`ifdef CFG_CHECKSUM_EN
          state_next = S_CHECK;
`else
          state_next = S_DONE;
          commit     = 1'b1;
`endif
        end
      end
`ifdef CFG_CHECKSUM_EN
      S_CHECK: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (sum_ok) begin
            state_next = S_DONE;
            commit     = 1'b1;
          end else begin
            state_next = S_ERROR;
            set_error  = 1'b1;
          end
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = s_ready;

  // ---------------------------------------------------------------------
  // Shadow register: one register per payload byte, written when the byte
  // counter selects it. Bits of the final byte beyond CFG_BITS are padding
  // and are not stored.
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < STORE_BYTES; gi++) begin : g_shadow
      localparam int W = (gi == CFG_BYTES-1) ? LAST_W : 8;
      logic [W-1:0] byte_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          byte_reg <= '0;
        else if (start_ok)
          byte_reg <= '0;
        else if (load_acc && (cnt_reg == CNT_W'(gi)))
          byte_reg <= s_data[W-1:0];
      end

      assign shadow[8*gi +: W] = byte_reg;
    end
  endgenerate

`ifdef CFG_CHECKSUM_EN
  assign commit_img = shadow;
`else
  // Commit happens on the edge accepting the last byte, so merge it live.
  assign commit_img = {s_data[LAST_W-1:0], shadow};
`endif

  // ---------------------------------------------------------------------
  // Byte counter and committed image
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg       <= '0;
      cfg_reg       <= '0;
      cfg_valid_reg <= 1'b0;
    end else begin
      if (start_ok)      cnt_reg <= '0;
      else if (load_acc) cnt_reg <= cnt_reg + 1'b1;

      if (commit) begin
        cfg_reg       <= commit_img;
        cfg_valid_reg <= 1'b1;
      end
    end
  end

`ifdef CFG_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_reg   <= '0;
      error_reg <= 1'b0;
    end else begin
      if (start_ok)      sum_reg <= '0;
      else if (load_acc) sum_reg <= sum_reg + s_data;

      if (start_ok)       error_reg <= 1'b0;
      else if (set_error) error_reg <= 1'b1;
    end
  end

  assign error = error_reg;
`else
  assign error = 1'b0;
`endif

  // Shadow packing, LSB first: brb, bsb, lb, left, right, top, bottom.
  assign brbselect      = cfg_reg[0       +: BRB_W];
  assign bsbselect      = cfg_reg[OFF_BSB +: BSB_W];
  assign lbselect       = cfg_reg[OFF_LB  +: LB_W];
  assign leftioselect   = cfg_reg[OFF_L   +: IO_W];
  assign rightioselect  = cfg_reg[OFF_R   +: IO_W];
  assign topioselect    = cfg_reg[OFF_T   +: IO_W];
  assign bottomioselect = cfg_reg[OFF_B   +: IO_W];
  assign cfg_valid      = cfg_valid_reg;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Testbench for fpga_cfg_loader (ROWS=1). Stimulus issues framed loads with
// random payloads; the expected committed image is pushed to a scoreboard
// queue and a monitor compares it when busy falls.
module tb_fpga_cfg_loader;

  localparam int         ROWS      = 1;
  localparam logic [7:0] SYNC      = 8'hA5;
  localparam int         BRB_W     = 180*(ROWS+1);
  localparam int         BSB_W     = 432*ROWS;
  localparam int         LB_W      = 20*ROWS;
  localparam int         IO_W      = 6*(ROWS+1);
  localparam int         CFG_BITS  = BRB_W + BSB_W + LB_W + 4*IO_W;
  localparam int         CFG_BYTES = (CFG_BITS + 7) / 8;

  logic                    clk = 1'b0;
  logic                    rst, start, s_valid, s_ready;
  logic [7:0]              s_data;
  logic [BRB_W-1:0]        brbselect;
  logic [BSB_W-1:0]        bsbselect;
  logic [LB_W-1:0]         lbselect;
  logic [IO_W-1:0]         leftioselect, rightioselect, topioselect, bottomioselect;
  logic                    cfg_valid, busy, error;

  fpga_cfg_loader #(.ROWS(ROWS), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .brbselect(brbselect), .bsbselect(bsbselect), .lbselect(lbselect),
    .leftioselect(leftioselect), .rightioselect(rightioselect),
    .topioselect(topioselect), .bottomioselect(bottomioselect),
    .cfg_valid(cfg_valid), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CFG_BITS-1:0] img;
    logic                valid;
    logic                err;
  } exp_t;

  exp_t                sb[$];
  int                  tests_run    = 0;
  int                  tests_failed = 0;
  int                  loads_seen   = 0;
  logic [7:0]          pay [CFG_BYTES];
  logic [CFG_BITS-1:0] prev_img;
  logic                prev_valid;
  logic                busy_q = 1'b0;

  task automatic chk(input string nm, input logic [CFG_BITS-1:0] act,
                     input logic [CFG_BITS-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Field of a packed image: w bits starting at bit off.
  function automatic logic [CFG_BITS-1:0] field(input logic [CFG_BITS-1:0] img,
                                                input int off, input int w);
    logic [CFG_BITS-1:0] m;
    m = '1;
    m = m >> (CFG_BITS - w);
    return (img >> off) & m;
  endfunction

  // Image the fabric should see: payload bytes concatenated LSB first,
  // truncated to CFG_BITS.
  function automatic logic [CFG_BITS-1:0] build_img();
    logic [CFG_BITS-1:0] r;
    r = '0;
    for (int k = 0; k < CFG_BYTES; k++)
      for (int b = 0; b < 8; b++)
        if (8*k + b < CFG_BITS) r[8*k + b] = pay[k][b];
    return r;
  endfunction

  task automatic chk_bus(input string tag, input logic [CFG_BITS-1:0] img);
    int off;
    off = 0;
    chk({tag, "_brb"},    CFG_BITS'(brbselect),      field(img, off, BRB_W)); off += BRB_W;
    chk({tag, "_bsb"},    CFG_BITS'(bsbselect),      field(img, off, BSB_W)); off += BSB_W;
    chk({tag, "_lb"},     CFG_BITS'(lbselect),       field(img, off, LB_W));  off += LB_W;
    chk({tag, "_left"},   CFG_BITS'(leftioselect),   field(img, off, IO_W));  off += IO_W;
    chk({tag, "_right"},  CFG_BITS'(rightioselect),  field(img, off, IO_W));  off += IO_W;
    chk({tag, "_top"},    CFG_BITS'(topioselect),    field(img, off, IO_W));  off += IO_W;
    chk({tag, "_bottom"}, CFG_BITS'(bottomioselect), field(img, off, IO_W));
  endtask

  task automatic chk_idle(input string tag);
    chk_bus(tag, '0);
    chk({tag, "_cfg_valid"}, CFG_BITS'(cfg_valid), '0);
    chk({tag, "_busy"},      CFG_BITS'(busy),      '0);
    chk({tag, "_s_ready"},   CFG_BITS'(s_ready),   '0);
    chk({tag, "_error"},     CFG_BITS'(error),     '0);
  endtask

  // Monitor: a load has finished when busy falls.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_q = 1'b0;
    end else begin
      if (busy_q && !busy) begin
        loads_seen++;
        if (sb.size() == 0) begin
          chk("unexpected_completion", CFG_BITS'(1), CFG_BITS'(0));
        end else begin
          e = sb.pop_front();
          chk_bus("commit", e.img);
          chk("cfg_valid", CFG_BITS'(cfg_valid), CFG_BITS'(e.valid));
          chk("error",     CFG_BITS'(error),     CFG_BITS'(e.err));
          $display("[TB] load %0d complete: cfg_valid=%0b error=%0b (expected %0b/%0b)",
                   loads_seen, cfg_valid, error, e.valid, e.err);
        end
      end
      busy_q = busy;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte; consumes one cycle (two with a gap), starts/ends at negedge.
  task automatic push_byte(input logic [7:0] b, input bit gap);
    if (gap) begin
      s_valid = 1'b0;
      @(negedge clk);
      chk("s_ready_in_gap", CFG_BITS'(s_ready), CFG_BITS'(1));
    end
    s_valid = 1'b1;
    s_data  = b;
    @(negedge clk);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("completion_timeout", CFG_BITS'(sb.size()), '0);
      sb.delete();
    end
  endtask

  task automatic do_load(input int njunk, input bit gap, input int start_at,
                         input int rst_at, input bit bad);
    logic [CFG_BITS-1:0] img;
    logic [7:0]          b;
    int                  sum;
    exp_t                e;

    chk("busy_before_start", CFG_BITS'(busy), '0);
    pulse_start();
    chk("s_ready_after_start", CFG_BITS'(s_ready), CFG_BITS'(1));
    chk("busy_after_start",    CFG_BITS'(busy),    CFG_BITS'(1));

    for (int j = 0; j < njunk; j++) begin
      if (j == 0)      b = 8'h00;
      else if (j == 1) b = 8'h13;
      else begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = b ^ 8'h01;
      end
      push_byte(b, gap);
    end
    push_byte(SYNC, gap);

    img = build_img();
    sum = 0;
    for (int k = 0; k < CFG_BYTES; k++) begin
      if (k == rst_at) begin
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk_idle("mid_rst");
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        prev_img   = '0;
        prev_valid = 1'b0;
        return;
      end
`ifndef CFG_CHECKSUM_EN
      if (k == CFG_BYTES-1) begin
        e.img = img; e.valid = 1'b1; e.err = 1'b0;
        sb.push_back(e);
      end
`endif
      if (k == start_at) start = 1'b1;
      push_byte(pay[k], gap);
      start = 1'b0;
      sum += int'(pay[k]);
    end

`ifdef CFG_CHECKSUM_EN
    b = 8'((256 - (sum % 256)) % 256);
    if (bad) begin
      b = b ^ 8'h01;
      e.img = prev_img; e.valid = prev_valid; e.err = 1'b1;
    end else begin
      e.img = img; e.valid = 1'b1; e.err = 1'b0;
    end
    sb.push_back(e);
    push_byte(b, gap);
`endif
    s_valid = 1'b0;

    if (!bad) begin
      prev_img   = img;
      prev_valid = 1'b1;
    end
    wait_done();
    chk("s_ready_after_load", CFG_BITS'(s_ready), '0);
    chk("busy_after_load",    CFG_BITS'(busy),    '0);
  endtask

  task automatic rand_payload();
    for (int k = 0; k < CFG_BYTES; k++) pay[k] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    s_valid    = 1'b0;
    s_data     = 8'h00;
    prev_img   = '0;
    prev_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk_idle("in_rst");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("after_rst");

    // Deterministic image: byte k = k, two junk bytes ahead of sync.
    for (int k = 0; k < CFG_BYTES; k++) pay[k] = 8'(k);
    do_load(2, 1'b0, -1, -1, 1'b0);

    // s_valid every other cycle, start pulsed mid-payload (must be ignored).
    rand_payload();
    do_load(3, 1'b1, 30, -1, 1'b0);

`ifdef CFG_CHECKSUM_EN
    // Bad checksum keeps the previous image, then a good load clears error.
    rand_payload();
    do_load(0, 1'b0, -1, -1, 1'b1);
    rand_payload();
    do_load(1, 1'b0, -1, -1, 1'b0);
`endif

    // Reset during payload byte 50, then a clean load.
    rand_payload();
    do_load(1, 1'b0, -1, 50, 1'b0);
    chk_idle("post_mid_rst");
    rand_payload();
    do_load(0, 1'b0, -1, -1, 1'b0);

    for (int n = 0; n < 3; n++) begin
      rand_payload();
      do_load(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), -1, -1, 1'b0);
    end

    chk("scoreboard_empty", CFG_BITS'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
